// File: rtl/memgame_pkg.sv
// Shared types and helpers for the memory game blocks
// (LED playback, input judge, game controller).
package memgame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } judge_state_t;

    localparam int unsigned MAX_SEQ  = 8;
    localparam int unsigned NIBBLE_W = 4;

    // Map a one-hot button vector to its game value 1..MAX_SEQ (0 when no bit is set)
    function automatic logic [NIBBLE_W-1:0] onehot_to_value(input logic [MAX_SEQ-1:0] onehot);
        logic [NIBBLE_W-1:0] value;
        value = '0;
        for (int unsigned i = 0; i < MAX_SEQ; i++) begin
            if (onehot[i]) begin
                value = NIBBLE_W'(i + 1);
            end
        end
        return value;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a per-bit stability counter.
// A bit of `clean` follows the synchronized input only after it has
// differed from `clean` for STABLE_CYCLES consecutive cycles.
module button_debouncer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);

    localparam int unsigned           CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;

    // Bring the asynchronous button levels into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-bit stability counter; any return to the accepted level restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            clean <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    clean[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_judge.sv
// Captures the player's button entries for one round and judges them
// against the answer sequence shown by LED playback.
module input_judge
    import memgame_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned ENTRY_TIMEOUT   = 150_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_input,
    input  logic [3:0]  difficulty_k,
    input  logic [31:0] answer_seq,
    input  logic [7:0]  btn_in,
    output logic        busy,
    output logic [3:0]  entry_cnt,
    output logic [31:0] entered_seq,
    output logic [7:0]  led_echo,
    output logic        judge_done,
    output logic        judge_pass,
    output logic        judge_timeout
);

    localparam logic [27:0] TIMER_LAST = 28'(ENTRY_TIMEOUT - 1);

    judge_state_t   state;
    logic [7:0]     btn_db;
    logic [7:0]     btn_db_q;
    logic [31:0]    seq_lat;
    logic [3:0]     k_lat;
    logic [27:0]    timer;

    logic           is_onehot;
    logic           press;
    logic [3:0]     press_val;
    logic [3:0]     expected_val;
    logic [3:0]     k_clamped;
    logic [4:0]     nib_base;

    button_debouncer #(
        .WIDTH         (MAX_SEQ),
        .STABLE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_in),
        .clean (btn_db)
    );

    // Previous debounced vector, used to find rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_q <= '0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    // Press detection, expected nibble lookup and k clamping
    always_comb begin
        is_onehot    = (btn_db != 8'd0) && ((btn_db & (btn_db - 8'd1)) == 8'd0);
        press        = is_onehot && ((btn_db & ~btn_db_q) != 8'd0);
        press_val    = onehot_to_value(btn_db);
        nib_base     = {entry_cnt[2:0], 2'b00};
        expected_val = seq_lat[nib_base +: NIBBLE_W];
        if (difficulty_k == 4'd0) begin
            k_clamped = 4'd1;
        end else if (difficulty_k > 4'(MAX_SEQ)) begin
            k_clamped = 4'(MAX_SEQ);
        end else begin
            k_clamped = difficulty_k;
        end
    end

    // Session FSM with registered outputs; start_input restarts from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            seq_lat       <= '0;
            k_lat         <= '0;
            timer         <= '0;
            busy          <= 1'b0;
            entry_cnt     <= '0;
            entered_seq   <= '0;
            led_echo      <= '0;
            judge_done    <= 1'b0;
            judge_pass    <= 1'b0;
            judge_timeout <= 1'b0;
        end else begin
            judge_done <= 1'b0;
            if (start_input) begin
                seq_lat       <= answer_seq;
                k_lat         <= k_clamped;
                entry_cnt     <= '0;
                entered_seq   <= '0;
                judge_pass    <= 1'b0;
                judge_timeout <= 1'b0;
                timer         <= '0;
                busy          <= 1'b1;
                if (btn_db != 8'd0) begin
                    state    <= WAIT_RELEASE;
                    led_echo <= btn_db;
                end else begin
                    state    <= WAIT_PRESS;
                    led_echo <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        led_echo <= '0;
                    end
                    WAIT_PRESS: begin
                        // A press takes priority over a timeout in the same cycle
                        if (press) begin
                            entered_seq[nib_base +: NIBBLE_W] <= press_val;
                            entry_cnt <= entry_cnt + 4'd1;
                            timer     <= '0;
                            if (press_val != expected_val) begin
                                state      <= DONE;
                                judge_done <= 1'b1;
                                busy       <= 1'b0;
                                judge_pass <= 1'b0;
                            end else if ((entry_cnt + 4'd1) == k_lat) begin
                                state      <= DONE;
                                judge_done <= 1'b1;
                                busy       <= 1'b0;
                                judge_pass <= 1'b1;
                            end else begin
                                state    <= WAIT_RELEASE;
                                led_echo <= btn_db;
                            end
                        end else if (timer == TIMER_LAST) begin
                            state         <= DONE;
                            judge_done    <= 1'b1;
                            busy          <= 1'b0;
                            judge_pass    <= 1'b0;
                            judge_timeout <= 1'b1;
                        end else begin
                            timer <= timer + 28'd1;
                        end
                    end
                    WAIT_RELEASE: begin
                        timer <= '0;
                        if (btn_db == 8'd0) begin
                            state    <= WAIT_PRESS;
                            led_echo <= '0;
                        end else begin
                            led_echo <= btn_db;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
